// File: rtl/cart_pkg.sv
// cart_pkg: source encoding and constants shared by the cartridge PROM arbiter and its clients.
package cart_pkg;
    typedef enum logic {SRC_CPU, SRC_DMA} cart_src_t;
    localparam int ROM_WINDOW_BIT = 15;
    localparam logic [7:0] OPEN_BUS = 8'hFF;
endpackage

// File: rtl/cart_arbiter.sv
// cart_arbiter: round-robin CPU/DMA arbiter for the synchronous cartridge PROM with a one-stage return path.
// Define CART_DMA_LOCK_EN to let a granted DMA keep the PROM for as long as it holds dma_req.
module cart_arbiter
    import cart_pkg::*;
#(
    parameter int ROM_ADDR_W = 15,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [15:0]           cpu_addr,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_W-1:0]     cpu_rdata,
    input  logic                  dma_req,
    input  logic [15:0]           dma_addr,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_W-1:0]     dma_rdata,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0]     rom_data
);
    cart_src_t             r_last_src;
    cart_src_t             r_pend_src;
    logic                  r_pend_valid;
    logic                  r_pend_oor;
    logic [ROM_ADDR_W-1:0] r_rom_addr;
    logic [DATA_W-1:0]     r_cpu_rdata;
    logic [DATA_W-1:0]     r_dma_rdata;
    logic                  w_cpu_wins;
    logic                  w_any_gnt;
    logic [15:0]           w_gnt_addr;
    logic [DATA_W-1:0]     w_ret;

`ifdef CART_DMA_LOCK_EN
    logic r_lock;
    assign w_cpu_wins = !r_lock && r_last_src == SRC_DMA;
    // the lock persists only while DMA keeps asking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_lock <= 1'b0;
        else
            r_lock <= dma_gnt || (r_lock && dma_req);
    end
`else
    assign w_cpu_wins = r_last_src == SRC_DMA;
`endif

    // grants are masked during reset because they are combinational
    assign cpu_gnt    = rst && cpu_req && (!dma_req || w_cpu_wins);
    assign dma_gnt    = rst && dma_req && !cpu_gnt;
    assign w_any_gnt  = cpu_gnt || dma_gnt;
    assign w_gnt_addr = cpu_gnt ? cpu_addr : dma_addr;
    assign rom_addr   = w_any_gnt ? w_gnt_addr[ROM_ADDR_W-1:0] : r_rom_addr;
    assign w_ret      = r_pend_oor ? DATA_W'(OPEN_BUS) : rom_data;
    assign cpu_rvalid = r_pend_valid && r_pend_src == SRC_CPU;
    assign dma_rvalid = r_pend_valid && r_pend_src == SRC_DMA;
    assign cpu_rdata  = cpu_rvalid ? w_ret : r_cpu_rdata;
    assign dma_rdata  = dma_rvalid ? w_ret : r_dma_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_src   <= SRC_DMA;
            r_pend_src   <= SRC_CPU;
            r_pend_valid <= 1'b0;
            r_pend_oor   <= 1'b0;
            r_rom_addr   <= '0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
        end else begin
            r_pend_valid <= w_any_gnt;
            r_pend_src   <= dma_gnt ? SRC_DMA : SRC_CPU;
            r_pend_oor   <= w_gnt_addr[ROM_WINDOW_BIT];
            r_cpu_rdata  <= cpu_rdata;
            r_dma_rdata  <= dma_rdata;
            if (w_any_gnt) begin
                r_rom_addr <= w_gnt_addr[ROM_ADDR_W-1:0];
                r_last_src <= dma_gnt ? SRC_DMA : SRC_CPU;
            end
        end
    end
endmodule

// File: tb/tb_cart_arbiter.sv
// tb_cart_arbiter: directed and random checks of cart_arbiter against a transaction-level model with a PROM array.
module tb_cart_arbiter;
`ifdef CART_DMA_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0, dma_req = 1'b0;
    logic [15:0] cpu_addr = '0, dma_addr = '0;
    logic        cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid;
    logic [7:0]  cpu_rdata, dma_rdata, rom_data;
    logic [14:0] rom_addr;
    logic [7:0]  mem [0:32767];
    int          checks = 0, passes = 0;
    int          n_cpu, n_dma;

    // model: who was served last, whether DMA owns the bus, and the read in flight
    bit          m_last_dma, m_lock, m_pv, m_ps_dma;
    logic [7:0]  m_pd, m_crd, m_drd;
    logic [14:0] m_rom;
    bit          e_cg, e_dg, o_cg, o_dg, o_dv;

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= mem[rom_addr];

    cart_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_gnt(dma_gnt),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    task automatic model_reset();
        m_last_dma = 1'b1;
        m_lock = 1'b0;
        m_pv = 1'b0;
        m_crd = 8'h00;
        m_drd = 8'h00;
        m_rom = '0;
    endtask

    // called just after a falling edge with inputs already driven; returns at the next falling edge
    task automatic cycle();
        logic [15:0] ga;
        #2;
        if (!rst) begin
            e_cg = 1'b0;
            e_dg = 1'b0;
        end else if (cpu_req && dma_req) begin
            e_dg = (LOCK && m_lock) || !m_last_dma;
            e_cg = !e_dg;
        end else begin
            e_cg = cpu_req;
            e_dg = dma_req;
        end
        ga = e_cg ? cpu_addr : dma_addr;
        o_cg = cpu_gnt;
        o_dg = dma_gnt;
        o_dv = dma_rvalid;
        chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
        chk("dma_gnt", 32'(dma_gnt), 32'(e_dg));
        chk("rom_addr", 32'(rom_addr), 32'((e_cg || e_dg) ? ga[14:0] : m_rom));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_pv && !m_ps_dma));
        chk("dma_rvalid", 32'(dma_rvalid), 32'(m_pv && m_ps_dma));
        chk("cpu_rdata", 32'(cpu_rdata), 32'((m_pv && !m_ps_dma) ? m_pd : m_crd));
        chk("dma_rdata", 32'(dma_rdata), 32'((m_pv && m_ps_dma) ? m_pd : m_drd));
        if (rst) begin
            if (m_pv && m_ps_dma) m_drd = m_pd;
            if (m_pv && !m_ps_dma) m_crd = m_pd;
            m_pv = e_cg || e_dg;
            m_ps_dma = e_dg;
            m_pd = ga[15] ? 8'hFF : mem[ga[14:0]];
            if (m_pv) begin
                m_rom = ga[14:0];
                m_last_dma = e_dg;
            end
            m_lock = e_dg || (m_lock && dma_req);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
        mem[15'h0100] = 8'h3C;
        mem[15'h4000] = 8'h5A;
        model_reset();
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b1;
        // single CPU read of PROM[0x100]
        cpu_req = 1'b1;
        cpu_addr = 16'h0100;
        cycle();
        chk("t1_gnt", 32'(o_cg), 32'd1);
        cpu_req = 1'b0;
        cycle();
        chk("t1_rdata", 32'(cpu_rdata), 32'h3C);
        // fresh reset, then continuous contention
        rst = 1'b0;
        model_reset();
        cycle();
        rst = 1'b1;
        cpu_addr = 16'h0000;
        dma_addr = 16'h0010;
`ifdef CART_DMA_LOCK_EN
        dma_req = 1'b1;
        n_cpu = 0;
        n_dma = 0;
        for (int i = 0; i < 160; i++) begin
            cpu_req = (i != 0);
            cycle();
            n_cpu += int'(o_cg);
            n_dma += int'(o_dg);
        end
        chk("lock_dma_grants", 32'(n_dma), 32'd160);
        chk("lock_cpu_grants", 32'(n_cpu), 32'd0);
        dma_req = 1'b0;
        cycle();
        chk("lock_release_cpu", 32'(o_cg), 32'd1);
`else
        cpu_req = 1'b1;
        dma_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("alt_cpu", 32'(o_cg), 32'(i % 2 == 0));
        end
`endif
        cpu_req = 1'b0;
        dma_req = 1'b0;
        cycle();
        // out-of-window CPU read returns open bus
        cpu_req = 1'b1;
        cpu_addr = 16'hC000;
        cycle();
        cpu_req = 1'b0;
        cycle();
        chk("oor_rdata", 32'(cpu_rdata), 32'hFF);
        // reset lands while a DMA read is in flight
        dma_req = 1'b1;
        dma_addr = 16'h0123;
        cycle();
        dma_req = 1'b0;
        rst = 1'b0;
        model_reset();
        cycle();
        chk("rst_no_rvalid", 32'(o_dv), 32'd0);
        rst = 1'b1;
        cpu_req = 1'b1;
        dma_req = 1'b1;
        cycle();
        chk("rst_tie_cpu", 32'(o_cg), 32'd1);
        cpu_req = 1'b0;
        dma_req = 1'b0;
        cycle();
        // CPU gives up while losing to DMA
        cpu_req = 1'b1;
        cpu_addr = 16'h0200;
        cycle();
        dma_req = 1'b1;
        dma_addr = 16'h0300;
        n_dma = 0;
        for (int i = 0; i < 4; i++) begin
            cpu_req = (i == 0);
            cycle();
            n_dma += int'(o_dg);
        end
        chk("drop_dma_grants", 32'(n_dma), 32'd4);
        dma_req = 1'b0;
        cycle();
        // random traffic honouring hold-until-granted, with occasional abandon
        for (int i = 0; i < 400; i++) begin
            if (cpu_req && !e_cg) cpu_req = ($urandom_range(0, 7) != 0);
            else begin
                cpu_req = 1'($urandom_range(0, 1));
                cpu_addr = 16'($urandom);
            end
            if (dma_req && !e_dg) dma_req = ($urandom_range(0, 7) != 0);
            else begin
                dma_req = ($urandom_range(0, 3) != 0);
                dma_addr = 16'($urandom);
            end
            cycle();
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        cycle();
        cycle();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
